// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte/state constants, the InvSubBytes
// sequencer FSM states and the LANES legality check.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTE_W  = 8;
   localparam int AES_NBYTES  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } isb_state_e;

   function automatic bit lanes_legal(int lanes);
      return (lanes == 1) || (lanes == 2) ||
             (lanes == 4) || (lanes == 8) ||
             (lanes == 16);
   endfunction

endpackage

// File: rtl/inv_subbytes_seq_if.sv
// inv_subbytes_seq_if: upstream state in / downstream result out.
// master = round controller side, slave = sequencer side.
interface inv_subbytes_seq_if;
   import aes_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [AES_STATE_W-1:0] in_state;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_STATE_W-1:0] out_state;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state
   );

endinterface

// File: rtl/inv_subbytes_lane_mux.sv
// inv_subbytes_lane_mux: picks LANES bytes of a state by beat index
// and holds the working state, overwritten beat-by-beat with results.
// Ports: clk/rst; ld_i/ld_state_i load a new state;
// rd_state_i/rd_idx_i -> rd_bytes_o select one beat's bytes;
// wr_en_i/wr_idx_i/wr_bytes_i write one beat back; state_o = register.
module inv_subbytes_lane_mux
   import aes_pkg::*;
#(
   parameter  int LANES = 4,
   localparam int BEATS = AES_NBYTES / LANES,
   localparam int CNT_W = $clog2(BEATS) + 1,
   localparam int SL_W  = LANES * AES_BYTE_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ld_i,
   input  logic [AES_STATE_W-1:0] ld_state_i,
   input  logic [AES_STATE_W-1:0] rd_state_i,
   input  logic [CNT_W-1:0]       rd_idx_i,
   output logic [SL_W-1:0]        rd_bytes_o,
   input  logic                   wr_en_i,
   input  logic [CNT_W-1:0]       wr_idx_i,
   input  logic [SL_W-1:0]        wr_bytes_i,
   output logic [AES_STATE_W-1:0] state_o
);

   logic [AES_STATE_W-1:0] state_q, state_d;

   // Beat b covers bytes b*LANES .. b*LANES+LANES-1, i.e. one
   // contiguous slice; lane j is byte j inside that slice.
   always_comb begin
      rd_bytes_o = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (rd_idx_i == CNT_W'(b)) begin
            rd_bytes_o = rd_state_i[b*SL_W +: SL_W];
         end
      end
   end

   // In-place update is safe: a beat's source bytes were already
   // latched into the address register before its result returns.
   always_comb begin
      state_d = state_q;
      if (ld_i) begin
         state_d = ld_state_i;
      end else if (wr_en_i) begin
         for (int b = 0; b < BEATS; b++) begin
            if (wr_idx_i == CNT_W'(b)) begin
               state_d[b*SL_W +: SL_W] = wr_bytes_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: InvSubBytes over 128 bits via LANES shared
// 1-cycle-latency inverse S-box ports, BEATS = 16/LANES beats/block.
// Ports: clk, rst (sync, high); io = state in/out handshake;
// sbox_en/sbox_addr out, sbox_data in (one cycle later); busy.
// INV_SUBBYTES_STATS_EN adds blk_cnt (saturating handshake count).
module inv_subbytes_seq
   import aes_pkg::*;
#(
   parameter  int LANES = 4,
   localparam int BEATS = AES_NBYTES / LANES,
   localparam int CNT_W = $clog2(BEATS) + 1,
   localparam int SL_W  = LANES * AES_BYTE_W
) (
   input  logic                clk,
   input  logic                rst,
   inv_subbytes_seq_if.slave   io,
   output logic                sbox_en,
   output logic [SL_W-1:0]     sbox_addr,
   input  logic [SL_W-1:0]     sbox_data,
   output logic                busy
`ifdef INV_SUBBYTES_STATS_EN
   ,
   output logic [31:0]         blk_cnt
`endif
);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("LANES must be 1, 2, 4, 8 or 16");
   end

   isb_state_e             st_q, st_d;
   logic [CNT_W-1:0]       iss_q, iss_d;
   logic [SL_W-1:0]        addr_q, addr_d;
   logic                   cap_vld_q;
   logic [CNT_W-1:0]       cap_idx_q;
   logic                   accept;
   logic                   issue_last;
   logic                   last_cap;
   logic                   out_vld;
   logic [CNT_W-1:0]       rd_idx;
   logic [SL_W-1:0]        rd_bytes;
   logic [AES_STATE_W-1:0] rd_src;
   logic [AES_STATE_W-1:0] state;

   assign io.in_ready = (st_q == IDLE) && !rst;
   assign accept      = io.in_valid && io.in_ready;
   assign sbox_en     = (st_q == RUN) &&
                        (iss_q < CNT_W'(BEATS));
   assign issue_last  = iss_q == CNT_W'(BEATS - 1);
   assign last_cap    = cap_vld_q &&
                        (cap_idx_q == CNT_W'(BEATS - 1));
   assign out_vld     = st_q == OUT;

   // Beat 0 addresses come straight from the incoming state so the
   // first lookup issues in the cycle right after acceptance.
   assign rd_src = accept ? io.in_state : state;
   assign rd_idx = accept ? '0 : iss_q + 1'b1;

   inv_subbytes_lane_mux #(.LANES(LANES)) u_mux (
      .clk        (clk),
      .rst        (rst),
      .ld_i       (accept),
      .ld_state_i (io.in_state),
      .rd_state_i (rd_src),
      .rd_idx_i   (rd_idx),
      .rd_bytes_o (rd_bytes),
      .wr_en_i    (cap_vld_q),
      .wr_idx_i   (cap_idx_q),
      .wr_bytes_i (sbox_data),
      .state_o    (state)
   );

   always_comb begin
      st_d   = st_q;
      iss_d  = iss_q;
      addr_d = addr_q;
      unique case (st_q)
         IDLE: begin
            if (accept) begin
               st_d   = RUN;
               iss_d  = '0;
               addr_d = rd_bytes;
            end
         end
         RUN: begin
            if (sbox_en) begin
               iss_d = iss_q + 1'b1;
               if (!issue_last) begin
                  addr_d = rd_bytes;
               end
            end
            if (last_cap) begin
               st_d = OUT;
            end
         end
         OUT: begin
            if (io.out_ready) begin
               st_d = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // cap_vld_q/cap_idx_q track which beat's data is on sbox_data
   // now; clearing them on reset drops any lookup still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= IDLE;
         iss_q     <= '0;
         addr_q    <= '0;
         cap_vld_q <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         st_q      <= st_d;
         iss_q     <= iss_d;
         addr_q    <= addr_d;
         cap_vld_q <= sbox_en;
         cap_idx_q <= iss_q;
      end
   end

   assign sbox_addr    = addr_q;
   assign io.out_valid = out_vld;
   assign io.out_state = state;
   assign busy         = st_q != IDLE;

`ifdef INV_SUBBYTES_STATS_EN
   logic [31:0] blk_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt_q <= '0;
      end else if (out_vld && io.out_ready &&
                   (blk_cnt_q != 32'hFFFF_FFFF)) begin
         blk_cnt_q <= blk_cnt_q + 32'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq: random and directed blocks through the
// sequencer, compared with a GF(2^8) inverse S-box reference.
module tb_inv_subbytes_seq;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_pass = 0;
   int   hs4 = 0;
   bit   sweep_go = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h",
                    tag, got, exp);
   endtask

   function automatic logic [7:0] gmul(logic [7:0] a,
                                       logic [7:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] x, int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // inverse affine map, then multiplicative inverse (0 -> 0)
   function automatic logic [7:0] inv_sbox(logic [7:0] x);
      logic [7:0] t;
      t = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
      if (t == 8'h00) return 8'h00;
      for (int a = 1; a < 256; a++)
         if (gmul(8'(a), t) == 8'h01) return 8'(a);
      return 8'h00;
   endfunction

   function automatic logic [127:0] ref_isb(logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return r;
   endfunction

   // ---------------- main DUT, LANES = 4 ----------------
   inv_subbytes_seq_if bus4 ();
   logic        en4;
   logic        busy4;
   logic [31:0] addr4;
   logic [31:0] data4;
`ifdef INV_SUBBYTES_STATS_EN
   logic [31:0] blk4;
`endif

   inv_subbytes_seq #(.LANES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .io        (bus4),
      .sbox_en   (en4),
      .sbox_addr (addr4),
      .sbox_data (data4),
      .busy      (busy4)
`ifdef INV_SUBBYTES_STATS_EN
      ,
      .blk_cnt   (blk4)
`endif
   );

   always @(posedge clk)
      if (en4)
         for (int j = 0; j < 4; j++)
            data4[8*j +: 8] <= inv_sbox(addr4[8*j +: 8]);

   always @(posedge clk)
      if (bus4.out_valid && bus4.out_ready) hs4 <= hs4 + 1;

   // ---------------- LANES sweep instances ----------------
   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 :
                         (g == 2) ? 8 : 16;
      inv_subbytes_seq_if bus ();
      logic           en;
      logic           bsy;
      logic [L*8-1:0] addr;
      logic [L*8-1:0] data;
      bit             done;
`ifdef INV_SUBBYTES_STATS_EN
      logic [31:0]    bc;
`endif

      inv_subbytes_seq #(.LANES(L)) u (
         .clk       (clk),
         .rst       (rst),
         .io        (bus),
         .sbox_en   (en),
         .sbox_addr (addr),
         .sbox_data (data),
         .busy      (bsy)
`ifdef INV_SUBBYTES_STATS_EN
         ,
         .blk_cnt   (bc)
`endif
      );

      always @(posedge clk)
         if (en)
            for (int j = 0; j < L; j++)
               data[8*j +: 8] <= inv_sbox(addr[8*j +: 8]);

      initial begin : drv
         logic [127:0]   s;
         logic [L*8-1:0] a0;
         int             lat;
         bus.in_valid  = 1'b0;
         bus.in_state  = '0;
         bus.out_ready = 1'b1;
         done = 1'b0;
         wait (sweep_go);
         s = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_state = s;
         @(posedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
         a0 = addr;
         lat = 0;
         while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("sw%0d_addr0", L), 128'(a0),
             128'(s[L*8-1:0]));
         chk($sformatf("sw%0d_lat", L), 128'(lat),
             128'(16 / L + 1));
         chk($sformatf("sw%0d_data", L), bus.out_state,
             ref_isb(s));
         @(negedge clk);
         done = 1'b1;
      end
   end

   // ---------------- main DUT helpers ----------------
   task automatic wait_out4(output int lat, output int en_n);
      lat = 0;
      en_n = 0;
      while (!bus4.out_valid && lat < 40) begin
         if (en4) en_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run4(input  logic [127:0] s,
                       output int           lat,
                       output int           en_n,
                       output logic [31:0]  a0);
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_state = s;
      chk("acc_rdy", 128'(bus4.in_ready), 128'(1));
      @(posedge clk);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      a0 = addr4;
      wait_out4(lat, en_n);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_in_ready"}, 128'(bus4.in_ready), '0);
      chk({tag, "_out_valid"}, 128'(bus4.out_valid), '0);
      chk({tag, "_out_state"}, bus4.out_state, '0);
      chk({tag, "_sbox_en"}, 128'(en4), '0);
      chk({tag, "_sbox_addr"}, 128'(addr4), '0);
      chk({tag, "_busy"}, 128'(busy4), '0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [127:0] s;
      logic [127:0] s2;
      logic [31:0]  a0;
      int           lat;
      int           en_n;
      int           hs0;
      int           k;

      rst = 1'b1;
      bus4.in_valid  = 1'b0;
      bus4.in_state  = '0;
      bus4.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("rst");
      rst = 1'b0;

      // LANES sweep
      sweep_go = 1'b1;
      k = 0;
      while (!(g_sw[0].done && g_sw[1].done &&
               g_sw[2].done && g_sw[3].done) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("sweep_done", 128'(k < 300), 128'(1));

      // all 0x63 -> all zero, 5-cycle latency, 4 issue beats
      run4({16{8'h63}}, lat, en_n, a0);
      chk("t63_lat", 128'(lat), 128'(5));
      chk("t63_en", 128'(en_n), 128'(4));
      chk("t63_data", bus4.out_state, '0);

      // known bytes, lane order
      s = {96'h0, 8'h63, 8'hFF, 8'h01, 8'h00};
      run4(s, lat, en_n, a0);
      chk("tkn_addr0", 128'(a0), 128'(32'h63FF0100));
      chk("tkn_data", bus4.out_state,
          {{12{8'h52}}, 8'h00, 8'h7D, 8'h09, 8'h52});
      chk("tkn_lat", 128'(lat), 128'(5));

      // random blocks, back to back
      for (int i = 0; i < 4; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         run4(s, lat, en_n, a0);
         chk("rnd_data", bus4.out_state, ref_isb(s));
         chk("rnd_lat", 128'(lat), 128'(5));
         chk("rnd_en", 128'(en_n), 128'(4));
         chk("rnd_addr0", 128'(a0), 128'(s[31:0]));
      end

      // output backpressure with a second block waiting
      @(negedge clk);
      bus4.out_ready = 1'b0;
      s  = {$urandom, $urandom, $urandom, $urandom};
      s2 = {$urandom, $urandom, $urandom, $urandom};
      run4(s, lat, en_n, a0);
      chk("bp_lat", 128'(lat), 128'(5));
      bus4.in_valid = 1'b1;
      bus4.in_state = s2;
      hs0 = hs4;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold", bus4.out_state, ref_isb(s));
         chk("bp_valid", 128'(bus4.out_valid), 128'(1));
         chk("bp_in_ready", 128'(bus4.in_ready), '0);
      end
      bus4.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_once", 128'(hs4 - hs0), 128'(1));
      chk("bp_valid_drop", 128'(bus4.out_valid), '0);
      chk("bp_rdy_again", 128'(bus4.in_ready), 128'(1));
      @(negedge clk);
      bus4.in_valid = 1'b0;
      chk("bp_2nd_busy", 128'(busy4), 128'(1));
      wait_out4(lat, en_n);
      chk("bp_2nd_lat", 128'(lat), 128'(5));
      chk("bp_2nd_data", bus4.out_state, ref_isb(s2));

      // reset in the second RUN cycle
      s = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_state = s;
      @(posedge clk);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("mid_rst");
      rst = 1'b0;
      run4('0, lat, en_n, a0);
      chk("post_rst_data", bus4.out_state, {16{8'h52}});
      chk("post_rst_lat", 128'(lat), 128'(5));

`ifdef INV_SUBBYTES_STATS_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("blk_clr", 128'(blk4), '0);
      for (int i = 0; i < 3; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         run4(s, lat, en_n, a0);
      end
      @(negedge clk);
      chk("blk_three", 128'(blk4), 128'(3));
      force dut.blk_cnt_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.blk_cnt_q;
      for (int i = 0; i < 2; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         run4(s, lat, en_n, a0);
      end
      @(negedge clk);
      chk("blk_sat", 128'(blk4), 128'(32'hFFFF_FFFF));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
